// File: rtl/serdes_frame_serializer.sv
// ---------------------------------------------------------------------------
// serdes_frame_serializer
//
// Takes pre-encoded 10-bit 8b10b symbols from a valid/ready stream, buffers
// them in a small FIFO and shifts them out one bit per enabled clock.
// Between frames (and whenever a frame starves mid-way) the line is filled
// with K28.5 commas whose polarity follows the running disparity.
//
// Ports
//   clk          system clock, everything on the rising edge
//   reset        synchronous, active-high
//   enable       bit-rate enable; when low all serializer state holds
//   s_data       encoded 10-bit symbol
//   s_last       final symbol of a frame
//   s_valid      upstream symbol valid
//   s_ready      FIFO can accept a symbol (not full)
//   tx_out       registered serial line
//   sym_strobe   1-cycle pulse while tx_out shows the first bit of a symbol
//   sof          1-cycle pulse with sym_strobe for the first data symbol
//   frame_active high from sof until the s_last symbol has been loaded
//   underrun     1-cycle pulse when a comma is inserted mid-frame
//   rd           running disparity, 0 = negative
//   fifo_level   occupied FIFO entries
// ---------------------------------------------------------------------------
module serdes_frame_serializer #(
    parameter int          FIFO_DEPTH = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int          MIN_IDLE   = 2,
    parameter logic [9:0]  COMMA_NEG  = 10'b0011111010,
    parameter logic [9:0]  COMMA_POS  = 10'b1100000101
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                enable,
    input  logic [9:0]                          s_data,
    input  logic                                s_last,
    input  logic                                s_valid,
    output logic                                s_ready,
    output logic                                tx_out,
    output logic                                sym_strobe,
    output logic                                sof,
    output logic                                frame_active,
    output logic                                underrun,
    output logic                                rd,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
    localparam int IDLE_W = $clog2(MIN_IDLE + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    // ------------------------------------------------------------------ FIFO
    // Entries are {last, data}. The head is read combinationally because the
    // symbol is chosen and its first bit driven on the same load edge.
    logic [10:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [10:0]      w_head;

    assign w_full     = (r_count == LVL_W'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push     = s_valid && !w_full;   // full blocks even with a same-cycle pop
    assign w_head     = r_mem[r_rd_ptr];
    assign s_ready    = !w_full;
    assign fifo_level = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {s_last, s_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------- symbol sequencer
    logic [3:0]        r_bit_cnt;
    logic [9:0]        r_shift;
    logic              r_tx;
    logic              r_rd;
    logic              r_strobe;
    logic              r_sof;
    logic              r_underrun;
    logic              r_frame_active;
    logic [IDLE_W-1:0] r_idle_cnt;
    state_t            r_state;

    logic              w_load;
    logic [9:0]        w_sym;
    logic [9:0]        w_sym_tx;     // w_sym in line order, bit 9 goes out first
    logic              w_sof;
    logic              w_underrun;
    logic              w_fa_next;
    logic [IDLE_W-1:0] w_idle_next;
    state_t            w_state_next;
    logic              w_flip;

    assign w_load = enable && (r_bit_cnt == 4'd9);
    assign w_flip = ($countones(w_sym) != 5);

    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_order
            assign w_sym_tx[gi] = MSB_FIRST ? w_sym[gi] : w_sym[9-gi];
        end
    endgenerate

    // Next-state / symbol selection; only acts on load cycles.
    always_comb begin
        w_state_next = r_state;
        w_idle_next  = r_idle_cnt;
        w_fa_next    = r_frame_active;
        w_sym        = r_rd ? COMMA_POS : COMMA_NEG;   // pre-load disparity
        w_pop        = 1'b0;
        w_sof        = 1'b0;
        w_underrun   = 1'b0;
        if (w_load) begin
            case (r_state)
                ST_IDLE: begin
                    if ((r_idle_cnt >= IDLE_W'(MIN_IDLE)) && !w_empty) begin
                        w_pop = 1'b1;
                        w_sym = w_head[9:0];
                        w_sof = 1'b1;
                        if (w_head[10]) begin
                            // single-symbol frame: never enters FRAME
                            w_idle_next = '0;
                            w_fa_next   = 1'b0;
                        end else begin
                            w_state_next = ST_FRAME;
                            w_fa_next    = 1'b1;
                        end
                    end else if (r_idle_cnt < IDLE_W'(MIN_IDLE)) begin
                        w_idle_next = r_idle_cnt + 1'b1;
                    end
                end
                ST_FRAME: begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                        w_sym = w_head[9:0];
                        if (w_head[10]) begin
                            w_state_next = ST_IDLE;
                            w_idle_next  = '0;
                            w_fa_next    = 1'b0;
                        end
                    end else begin
                        w_underrun = 1'b1;   // starved: comma, frame stays open
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_idle_cnt     <= '0;
            r_frame_active <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_idle_cnt     <= w_idle_next;
            r_frame_active <= w_fa_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt  <= 4'd9;
            r_shift    <= '0;
            r_tx       <= 1'b0;
            r_rd       <= 1'b0;
            r_strobe   <= 1'b0;
            r_sof      <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_strobe   <= 1'b0;
            r_sof      <= 1'b0;
            r_underrun <= 1'b0;
            if (enable) begin
                if (w_load) begin
                    r_tx       <= w_sym_tx[9];
                    r_shift    <= {w_sym_tx[8:0], 1'b0};
                    r_bit_cnt  <= 4'd0;
                    r_rd       <= r_rd ^ w_flip;
                    r_strobe   <= 1'b1;
                    r_sof      <= w_sof;
                    r_underrun <= w_underrun;
                end else begin
                    r_tx      <= r_shift[9];
                    r_shift   <= {r_shift[8:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end
        end
    end

    assign tx_out       = r_tx;
    assign sym_strobe   = r_strobe;
    assign sof          = r_sof;
    assign underrun     = r_underrun;
    assign frame_active = r_frame_active;
    assign rd           = r_rd;

endmodule

// File: tb/tb_serdes_frame_serializer.sv
// Scoreboard bench: a symbol-level model predicts what each load puts on the
// line; a negedge monitor pops those predictions and checks the serial bits.
module tb_serdes_frame_serializer;
    localparam int         DEPTH    = 8;
    localparam int         MIN_IDLE = 2;
    localparam logic [9:0] CN       = 10'b0011111010;
    localparam logic [9:0] CP       = 10'b1100000101;
    localparam logic [9:0] D00      = 10'b1001110100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [9:0] s_data = '0;
    logic       s_last = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready, tx_out, sym_strobe, sof, frame_active, underrun, rd;
    logic [3:0] fifo_level;

    logic       l_valid = 1'b0;
    logic       l_ready, l_tx, l_strobe, l_sof, l_fa, l_und, l_rd;
    logic [3:0] l_level;

    always #5 clk = ~clk;

    serdes_frame_serializer #(.FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b1), .MIN_IDLE(MIN_IDLE)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .s_data(s_data), .s_last(s_last),
        .s_valid(s_valid), .s_ready(s_ready), .tx_out(tx_out), .sym_strobe(sym_strobe),
        .sof(sof), .frame_active(frame_active), .underrun(underrun), .rd(rd),
        .fifo_level(fifo_level));

    serdes_frame_serializer #(.FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b0), .MIN_IDLE(MIN_IDLE)) u_dut_lsb (
        .clk(clk), .reset(reset), .enable(enable), .s_data(s_data), .s_last(s_last),
        .s_valid(l_valid), .s_ready(l_ready), .tx_out(l_tx), .sym_strobe(l_strobe),
        .sof(l_sof), .frame_active(l_fa), .underrun(l_und), .rd(l_rd),
        .fifo_level(l_level));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------- reference model
    typedef struct { logic [9:0] sym; bit sof; bit und; } exp_t;
    typedef struct { logic [9:0] data; bit last; } ent_t;
    exp_t exp_q[$];
    ent_t m_fifo[$];
    int   m_phase = 0;
    int   m_idle = 0;
    bit   m_in_frame = 0;
    bit   m_fa = 0;
    bit   m_rd = 0;
    bit   en_at_edge = 0;
    bit   rst_at_edge = 0;

    function automatic void model_load();
        logic [9:0] sym;
        bit   sofv = 0;
        bit   und = 0;
        ent_t e;
        sym = m_rd ? CP : CN;
        if (!m_in_frame) begin
            if (m_idle >= MIN_IDLE && m_fifo.size() > 0) begin
                e = m_fifo.pop_front();
                sym = e.data;
                sofv = 1;
                m_in_frame = !e.last;
                m_fa = !e.last;
                if (e.last) m_idle = 0;
            end else begin
                m_idle = (m_idle + 1 > MIN_IDLE) ? MIN_IDLE : m_idle + 1;
            end
        end else if (m_fifo.size() > 0) begin
            e = m_fifo.pop_front();
            sym = e.data;
            if (e.last) begin
                m_in_frame = 0;
                m_fa = 0;
                m_idle = 0;
            end
        end else begin
            und = 1;
        end
        if ($countones(sym) != 5) m_rd = !m_rd;
        exp_q.push_back('{sym, sofv, und});
    endfunction

    always @(posedge clk) begin
        bit acc;
        en_at_edge  = enable;
        rst_at_edge = reset;
        if (reset) begin
            m_fifo.delete();
            exp_q.delete();
            m_phase = 0; m_idle = 0; m_in_frame = 0; m_fa = 0; m_rd = 0;
        end else begin
            acc = s_valid && (m_fifo.size() < DEPTH);
            if (enable) begin
                if (m_phase == 0) model_load();
                m_phase = (m_phase + 1) % 10;
            end
            if (acc) m_fifo.push_back('{s_data, s_last});
        end
    end

    // ------------------------------------------------------------------ monitor
    int         bit_idx = 0;
    logic [9:0] got;
    logic [9:0] cur_line;
    exp_t       cur;
    logic       prev_tx = 1'b0;

    always @(negedge clk) begin
        if (rst_at_edge) begin
            bit_idx = 0;
            chk("reset_outs", {tx_out, sym_strobe, sof, underrun, frame_active, rd, s_ready}, 7'b0000001);
            chk("reset_level", fifo_level, 0);
        end else begin
            chk("s_ready", s_ready, (m_fifo.size() < DEPTH));
            chk("fifo_level", fifo_level, m_fifo.size());
            chk("frame_active", frame_active, m_fa);
            chk("rd", rd, m_rd);
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                if (bit_idx != 0) chk("sym_len", bit_idx, 10);
                chk("sym_strobe", sym_strobe, 1);
                chk("sof", sof, cur.sof);
                chk("underrun", underrun, cur.und);
                cur_line = cur.sym;
                got = {9'b0, tx_out};
                bit_idx = 1;
            end else begin
                chk("no_strobe", {sym_strobe, sof, underrun}, 0);
                if (!en_at_edge) begin
                    if (bit_idx > 0) chk("tx_hold", tx_out, prev_tx);
                end else if (bit_idx >= 1 && bit_idx < 10) begin
                    got = {got[8:0], tx_out};
                    bit_idx++;
                    if (bit_idx == 10) begin
                        chk("symbol", got, cur_line);
                        $display("sym exp=%b got=%b sof=%0d und=%0d rd=%0d", cur_line, got, cur.sof, cur.und, rd);
                    end
                end
            end
            prev_tx = tx_out;
        end
    end

    // LSB-first instance: its first comma after reset must read 0101111100.
    initial begin
        logic [9:0] lg;
        int n;
        n = 0;
        @(negedge clk);
        while (!(reset == 1'b0 && l_strobe) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("lsb_strobe_seen", (n < 40), 1);
        lg = {9'b0, l_tx};
        repeat (9) begin
            @(negedge clk);
            lg = {lg[8:0], l_tx};
        end
        chk("lsb_first_comma", lg, 10'b0101111100);
    end

    // ----------------------------------------------------------------- stimulus
    bit rand_en = 0;
    always @(posedge clk) begin
        #1;
        if (rand_en) enable = ($urandom_range(0, 3) != 0);
    end

    task automatic push(input logic [9:0] d, input bit last);
        bit ok;
        int n;
        s_data = d; s_last = last; s_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 3000);
        if (!ok) chk("push_timeout", 0, 1);
        s_valid = 1'b0;
    endtask

    task automatic wait_sof();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sof && n < 500);
        chk("sof_seen", sof, 1);
    endtask

    initial begin
        int len;
        reset = 1'b1; enable = 1'b1;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        repeat (60) @(posedge clk);
        #1;

        // three D0.0 symbols, last on the third
        push(D00, 0); push(D00, 0); push(D00, 1);
        repeat (80) @(posedge clk);
        #1;

        // fill while the serializer is frozen, then release
        enable = 1'b0;
        for (int i = 0; i < 8; i++) push(10'($urandom), 0);
        @(negedge clk);
        chk("full_ready", s_ready, 0);
        chk("full_level", fifo_level, 8);
        @(posedge clk);
        #1 enable = 1'b1;
        push(10'($urandom), 1);
        repeat (150) @(posedge clk);
        #1;

        // starved frame
        push(10'($urandom), 0); push(10'($urandom), 0);
        repeat (60) @(posedge clk);
        #1 push(10'($urandom), 1);
        repeat (60) @(posedge clk);
        #1;

        // enable gap of 5 cycles in the middle of a data symbol
        push(D00, 0); push(10'($urandom), 1);
        wait_sof();
        repeat (4) @(posedge clk);
        #1 enable = 1'b0;
        repeat (5) @(posedge clk);
        #1 enable = 1'b1;
        repeat (60) @(posedge clk);
        #1;

        // reset mid-frame with data still queued
        for (int i = 0; i < 5; i++) push(10'($urandom), 0);
        wait_sof();
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (60) @(posedge clk);
        #1;

        // random frames with random gaps and random enable
        rand_en = 1;
        for (int f = 0; f < 20; f++) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                push(10'($urandom), (i == len - 1));
                repeat ($urandom_range(0, 12)) @(posedge clk);
                #1;
            end
        end
        rand_en = 0;
        @(posedge clk);
        #1 enable = 1'b1;
        repeat (300) @(posedge clk);
        chk("drained", m_fifo.size(), 0);
        chk("drained_level", fifo_level, 0);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serdes_frame_serializer.md
Name: serdes_frame_serializer

Overview:
- Parametrised successor of the serdes transmitter path.
- Accepts pre-encoded 10-bit 8b10b symbols on a valid/ready stream with frame delimiting, and buffers them in an internal FIFO.
- Serialises one bit per enabled clock onto tx_out and fills inter-frame gaps with K28.5 commas of the correct running disparity.
- Sits between the 8b10b encoder and the line, and feeds serdes_receiver directly.

Parameters:
- FIFO_DEPTH, 8, symbol FIFO entries; power of 2, >=2.
- MSB_FIRST, 1, 1 = symbol bit 9 transmitted first; 0 = bit 0 first.
- MIN_IDLE, 2, minimum commas between frames, including after reset; >=1.
- COMMA_NEG, 10'b0011111010, K28.5 sent when RD is negative.
- COMMA_POS, 10'b1100000101, K28.5 sent when RD is positive.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  bit-rate enable; when low, all serializer state holds.
- s_data  in  10  encoded symbol.
- s_last  in  1  marks the final symbol of a frame.
- s_valid  in  1  upstream symbol valid.
- s_ready  out  1  FIFO can accept a symbol.
- tx_out  out  1  serial line, registered.
- sym_strobe  out  1  1-cycle pulse on the cycle tx_out shows the first bit of a symbol.
- sof  out  1  1-cycle pulse, coincident with sym_strobe, for the first data symbol of a frame.
- frame_active  out  1  high from sof until the s_last symbol has been loaded.
- underrun  out  1  1-cycle pulse when a comma is inserted mid-frame.
- rd  out  1  current running disparity; 0 = negative.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  number of occupied FIFO entries.

Behaviour:
- Reset values: tx_out=0, sym_strobe=0, sof=0, underrun=0, frame_active=0, rd=0, fifo_level=0, s_ready=1.
- Reset also sets: FIFO flushed, bit_cnt=9, idle_cnt=0, state=IDLE, shift register=0.
- Reset mid-symbol or mid-frame aborts immediately; nothing resumes.
- FIFO entry is 11 bits {last, data}.
- s_ready = !full.
- Push on s_valid&&s_ready, independent of enable.
- Pop only at symbol load. Push and pop in the same cycle are allowed; level is unchanged.
- A push is never accepted while full, including a simultaneous pop in that cycle. s_ready is registered-state based.
- Symbol timing: bit_cnt counts 0..9 on enabled cycles.
- Load occurs on an enabled cycle with bit_cnt==9. On that cycle:
  - the next symbol is chosen;
  - tx_out takes its first bit;
  - bit_cnt becomes 0;
  - sym_strobe pulses.
- The following 9 enabled cycles shift out the remaining bits in MSB_FIRST order.
- Symbol period is exactly 10 enabled cycles. Latency from reset release with enable=1: first bit on the first enabled cycle.
- enable=0: tx_out, bit_cnt, shift register, rd and state hold. Strobes are not generated.
- Disparity: at each load, the comma choice uses the pre-load rd (0 → COMMA_NEG, 1 → COMMA_POS).
- After each load, rd flips if popcount(symbol)!=5 and holds if popcount==5. This applies to data symbols and commas alike.
- State machine, evaluated at load only:
  - IDLE: send comma, idle_cnt++ (saturating).
    - If idle_cnt (post-increment) >= MIN_IDLE and the FIFO is non-empty at the next load → FRAME.
    - On that load, pop, send data, pulse sof, set frame_active.
  - FRAME with FIFO non-empty: pop and send.
    - If the popped last=1, go to IDLE, idle_cnt=0, and clear frame_active in the same cycle.
    - A single-symbol frame pulses sof with frame_active staying low.
  - FRAME with FIFO empty: send comma and pulse underrun. Stay in FRAME; frame_active stays 1 and rd updates normally.
- Data symbols are transmitted unmodified. The block does not check 8b10b legality or disparity of input symbols.

Test Plan:
- Reset 4 cycles, enable=1, no data → tx_out repeats 0011111010,1100000101 (MSB first); sym_strobe every 10 cycles; rd toggles 0,1,0,...; s_ready=1; fifo_level=0.
- Push 3× 10'b1001110100 (D0.0, 5 ones), last on third → after 2 commas: sof once, 30 data bits match, frame_active high for exactly 3 loads, rd unchanged across data, then commas resume with the correct polarity.
- enable=0, push 9 symbols → s_ready falls after 8th push; fifo_level=8; 9th held. Enable → all 9 symbols serialised in order, none lost.
- Push 2 symbols with last=0, then stall upstream → after 2 data symbols, comma of current rd inserted; underrun pulses once per inserted comma; frame_active=1. Push last → sent, frame_active clears.
- enable low 5 cycles at bit 4 of a data symbol → tx_out held during the gap; symbol spans 15 clocks; bit sequence identical.
- reset at bit 6 of a frame with fifo_level=3 → next cycle all outputs at reset values, s_ready=1. With enable=1, the first symbol loaded after release is COMMA_NEG.
- MSB_FIRST=0 → first comma appears on the line as 0101111100.
